// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and widths for the ID-stage branch resolve unit.
// Entry layout: {num, pred, addr}, with addr in the low word.
package branch_resolve_unit_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int BRU_ENTRY_W = 3 * WORD_SIZE;

  localparam int BRU_ADDR_OFS = 0;
  localparam int BRU_PRED_OFS = WORD_SIZE;
  localparam int BRU_NUM_OFS  = 2 * WORD_SIZE;

  typedef struct packed {
    logic [WORD_SIZE-1:0] num;
    logic [WORD_SIZE-1:0] pred;
    logic [WORD_SIZE-1:0] addr;
  } bru_entry_t;

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// Circular buffer of in-flight fetch entries.
// Supports push, pop and a whole-queue flush.
module bru_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [BRU_ENTRY_W-1:0] wdata,
  output logic [BRU_ENTRY_W-1:0] rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BRU_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the slot a same-cycle push lands in.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks fetch-side predictions against ID outcomes, redirects the PC
// on a mispredict and emits registered predictor training updates.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_push,
  input  logic [WORD_SIZE-1:0] if_addr,
  input  logic [WORD_SIZE-1:0] if_pred_addr,
  input  logic [WORD_SIZE-1:0] if_num_inst,
  input  logic                 id_valid,
  input  logic                 id_is_ctrl,
  input  logic                 id_taken,
  input  logic [WORD_SIZE-1:0] id_target,
  output logic                 jump,
  output logic [WORD_SIZE-1:0] jump_target,
  output logic [WORD_SIZE-1:0] jump_num_inst,
  output logic                 fetch_stall,
  output logic                 bp_update,
  output logic [WORD_SIZE-1:0] bp_update_pc,
  output logic [WORD_SIZE-1:0] bp_update_target,
  output logic                 bp_update_taken,
  output logic [CNT_WIDTH-1:0] mispredict_cnt,
  output logic                 proto_err
);

  bru_entry_t             wentry;
  logic [BRU_ENTRY_W-1:0] head;
  logic [WORD_SIZE-1:0]   head_addr;
  logic [WORD_SIZE-1:0]   head_pred;
  logic [WORD_SIZE-1:0]   head_num;
  logic [WORD_SIZE-1:0]   actual;
  logic                   q_full;
  logic                   q_empty;
  logic [$clog2(DEPTH):0] q_count;
  logic                   resolve;
  logic                   train;

  assign wentry = '{num: if_num_inst, pred: if_pred_addr, addr: if_addr};

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (if_push),
    .pop   (id_valid),
    .flush (jump),
    .wdata (wentry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign head_addr = head[BRU_ADDR_OFS +: WORD_SIZE];
  assign head_pred = head[BRU_PRED_OFS +: WORD_SIZE];
  assign head_num  = head[BRU_NUM_OFS  +: WORD_SIZE];

  assign resolve = id_valid & ~q_empty;
  assign train   = resolve & id_is_ctrl;
  assign actual  = (id_is_ctrl & id_taken) ? id_target
                                           : head_addr + 1'b1;

  assign jump          = resolve & (actual != head_pred);
  assign jump_target   = jump ? actual : '0;
  assign jump_num_inst = jump ? head_num : '0;
  assign fetch_stall   = q_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_update        <= 1'b0;
      bp_update_pc     <= '0;
      bp_update_target <= '0;
      bp_update_taken  <= 1'b0;
      mispredict_cnt   <= '0;
      proto_err        <= 1'b0;
    end else begin
      bp_update <= train;
      if (train) begin
        bp_update_pc     <= head_addr;
        bp_update_target <= actual;
        bp_update_taken  <= id_taken;
      end
      if (jump && !(&mispredict_cnt))
        mispredict_cnt <= mispredict_cnt + 1'b1;
      if (id_valid && q_count == '0)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Steps follow one linear sequence with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_push;
  logic [15:0] if_addr;
  logic [15:0] if_pred_addr;
  logic [15:0] if_num_inst;
  logic        id_valid;
  logic        id_is_ctrl;
  logic        id_taken;
  logic [15:0] id_target;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] jump_num_inst;
  logic        fetch_stall;
  logic        bp_update;
  logic [15:0] bp_update_pc;
  logic [15:0] bp_update_target;
  logic        bp_update_taken;
  logic [15:0] mispredict_cnt;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_push          (if_push),
    .if_addr          (if_addr),
    .if_pred_addr     (if_pred_addr),
    .if_num_inst      (if_num_inst),
    .id_valid         (id_valid),
    .id_is_ctrl       (id_is_ctrl),
    .id_taken         (id_taken),
    .id_target        (id_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .jump_num_inst    (jump_num_inst),
    .fetch_stall      (fetch_stall),
    .bp_update        (bp_update),
    .bp_update_pc     (bp_update_pc),
    .bp_update_target (bp_update_target),
    .bp_update_taken  (bp_update_taken),
    .mispredict_cnt   (mispredict_cnt),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_push      = 1'b0;
    if_addr      = '0;
    if_pred_addr = '0;
    if_num_inst  = '0;
    id_valid     = 1'b0;
    id_is_ctrl   = 1'b0;
    id_taken     = 1'b0;
    id_target    = '0;
  endtask

  task automatic drv_push(input logic [15:0] a, input logic [15:0] p,
                          input logic [15:0] n);
    if_push      = 1'b1;
    if_addr      = a;
    if_pred_addr = p;
    if_num_inst  = n;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_jump", 32'(jump), 0);
    chk("rst_stall", 32'(fetch_stall), 0);
    chk("rst_bpu", 32'(bp_update), 0);
    chk("rst_cnt", 32'(mispredict_cnt), 0);
    chk("rst_perr", 32'(proto_err), 0);
    reset = 1'b0;

    // mid-stream reset with three mispredicting entries queued
    for (int i = 0; i < 3; i++) begin
      drv_push(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'(i));
      tick();
    end
    idle();
    #1;
    chk("t1_stall3", 32'(fetch_stall), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t1_stall", 32'(fetch_stall), 0);
    chk("t1_jump", 32'(jump), 0);
    chk("t1_bpu", 32'(bp_update), 0);

    // non-control instruction, correctly predicted
    drv_push(16'h0010, 16'h0011, 16'd5);
    tick();
    idle();
    id_valid = 1'b1;
    #1;
    chk("t2_jump", 32'(jump), 0);
    chk("t2_tgt", 32'(jump_target), 0);
    chk("t2_num", 32'(jump_num_inst), 0);
    tick();
    idle();
    #1;
    chk("t2_bpu", 32'(bp_update), 0);
    chk("t2_perr", 32'(proto_err), 0);

    // taken branch predicted not-taken, wrong-path push discarded
    drv_push(16'h0020, 16'h0021, 16'd7);
    tick();
    drv_push(16'h0021, 16'h0099, 16'd8);
    id_valid   = 1'b1;
    id_is_ctrl = 1'b1;
    id_taken   = 1'b1;
    id_target  = 16'h0040;
    #1;
    chk("t3_jump", 32'(jump), 1);
    chk("t3_tgt", 32'(jump_target), 32'h40);
    chk("t3_num", 32'(jump_num_inst), 7);
    tick();
    idle();
    #1;
    chk("t3_bpu", 32'(bp_update), 1);
    chk("t3_bpc", 32'(bp_update_pc), 32'h20);
    chk("t3_btgt", 32'(bp_update_target), 32'h40);
    chk("t3_btkn", 32'(bp_update_taken), 1);
    chk("t3_cnt", 32'(mispredict_cnt), 1);
    drv_push(16'h0040, 16'h0041, 16'd1);
    tick();
    idle();
    id_valid = 1'b1;
    #1;
    chk("t3_discard", 32'(jump), 0);
    chk("t3_bpu_once", 32'(bp_update), 0);
    tick();
    idle();
    #1;
    chk("t3_bpu_nc", 32'(bp_update), 0);
    chk("t3_bpc_hold", 32'(bp_update_pc), 32'h20);

    // predicted taken, actually not taken
    drv_push(16'h0030, 16'h0050, 16'd9);
    tick();
    idle();
    id_valid   = 1'b1;
    id_is_ctrl = 1'b1;
    id_target  = 16'h0050;
    #1;
    chk("t4_jump", 32'(jump), 1);
    chk("t4_tgt", 32'(jump_target), 32'h31);
    chk("t4_num", 32'(jump_num_inst), 9);
    tick();
    idle();
    #1;
    chk("t4_bpu", 32'(bp_update), 1);
    chk("t4_bpc", 32'(bp_update_pc), 32'h30);
    chk("t4_btgt", 32'(bp_update_target), 32'h31);
    chk("t4_btkn", 32'(bp_update_taken), 0);
    chk("t4_cnt", 32'(mispredict_cnt), 2);

    // fill, overflow push ignored, pop+push while full
    for (int i = 0; i < 4; i++) begin
      drv_push(16'h0060 + 16'(i), 16'h0061 + 16'(i), 16'(i));
      #1;
      chk("t5_fill_stall", 32'(fetch_stall), 0);
      tick();
    end
    idle();
    #1;
    chk("t5_full", 32'(fetch_stall), 1);
    drv_push(16'h0070, 16'h0099, 16'h000e);
    tick();
    idle();
    #1;
    chk("t5_ovf_full", 32'(fetch_stall), 1);
    drv_push(16'h0064, 16'h0065, 16'd4);
    id_valid = 1'b1;
    #1;
    chk("t5_pp_jump", 32'(jump), 0);
    tick();
    idle();
    #1;
    chk("t5_pp_full", 32'(fetch_stall), 1);
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'b1;
      #1;
      chk("t5_drain_jump", 32'(jump), 0);
      tick();
      idle();
    end
    #1;
    chk("t5_drained", 32'(fetch_stall), 0);

    // resolve with empty queue, then PC wrap
    id_valid = 1'b1;
    #1;
    chk("t6_jump", 32'(jump), 0);
    tick();
    idle();
    #1;
    chk("t6_perr", 32'(proto_err), 1);
    tick();
    chk("t6_sticky", 32'(proto_err), 1);
    drv_push(16'hffff, 16'h0000, 16'd3);
    tick();
    idle();
    id_valid = 1'b1;
    #1;
    chk("t6_wrap_jump", 32'(jump), 0);
    chk("t6_wrap_tgt", 32'(jump_target), 0);
    tick();
    idle();
    #1;
    chk("t6_cnt", 32'(mispredict_cnt), 2);
    chk("t6_perr_hold", 32'(proto_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
